// File: rtl/sdr_stream_reader.sv
// Chunked SDRAM read sequencer: splits a long word read into engine-sized bursts and streams the words out over valid/ready.
// Optional read watchdog (adds err_timeout port): define SDR_STREAM_TIMEOUT_EN.

module sdr_stream_buf_word (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (load) q <= d;
    end
endmodule

module sdr_stream_reader #(
    parameter int MAX_NREAD      = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic [29:0]             total_words,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             sdr_baseaddr,
    output logic [29:0]             sdr_nelems,
    output logic                    sdr_readstart,
    input  logic                    sdr_readend,
    input  logic [32*MAX_NREAD-1:0] sdr_readdata,
    output logic [31:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
`ifdef SDR_STREAM_TIMEOUT_EN
    ,
    output logic                    err_timeout
`endif
);
    localparam int CW = $clog2(MAX_NREAD) + 1;
    localparam int IW = (MAX_NREAD > 1) ? $clog2(MAX_NREAD) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [29:0] remaining;
    } req_t;

    state_t                     state, state_nx;
    req_t                       req_q;
    logic [CW-1:0]              chunk_q;
    logic [CW-1:0]              chunk_nx;
    logic [IW-1:0]              idx_q;
    logic                       zero_done_q;
    logic [MAX_NREAD-1:0][31:0] rd_buf;
    logic                       buf_load;
    logic                       hs;
    logic                       last_word;
    logic                       accept;
    logic                       tmo_hit;

    assign accept    = (state == IDLE) && start && (total_words != '0);
    assign chunk_nx  = (req_q.remaining < 30'(MAX_NREAD)) ? req_q.remaining[CW-1:0] : CW'(MAX_NREAD);
    assign hs        = (state == DRAIN) && out_ready;
    assign last_word = (CW'(idx_q) == (chunk_q - CW'(1)));
    assign buf_load  = (state == WAIT_RD) && sdr_readend;

    // One slot per engine word; the whole flat buffer is captured on readend.
    genvar g;
    generate
        for (g = 0; g < MAX_NREAD; g++) begin : g_slot
            sdr_stream_buf_word u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (buf_load),
                .d       (sdr_readdata[32*g +: 32]),
                .q       (rd_buf[g])
            );
        end
    endgenerate

`ifdef SDR_STREAM_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit     = (state == WAIT_RD) && !sdr_readend && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE)        tmo_cnt <= '0;
            else if (state == WAIT_RD) tmo_cnt <= tmo_cnt + TW'(1);
            if ((state == IDLE) && start) err_q <= 1'b0;
            else if (tmo_hit)             err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT_RD;
            WAIT_RD: begin
                if (sdr_readend)  state_nx = DRAIN;
                else if (tmo_hit) state_nx = FINISH;
            end
            DRAIN:   if (hs && last_word) state_nx = (req_q.remaining != '0) ? ISSUE : FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q         <= '0;
            chunk_q       <= '0;
            idx_q         <= '0;
            zero_done_q   <= 1'b0;
            sdr_readstart <= 1'b0;
            sdr_baseaddr  <= '0;
            sdr_nelems    <= '0;
        end else begin
            sdr_readstart <= (state == ISSUE);
            zero_done_q   <= (state == IDLE) && start && (total_words == '0);
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q.addr      <= base_addr;
                        req_q.remaining <= total_words;
                    end
                end
                ISSUE: begin
                    sdr_baseaddr <= req_q.addr;
                    sdr_nelems   <= 30'(chunk_nx);
                    chunk_q      <= chunk_nx;
                end
                WAIT_RD: begin
                    // Advance past this chunk now so DRAIN already knows whether more follow.
                    if (sdr_readend) begin
                        req_q.addr      <= req_q.addr + (32'(chunk_q) << 2);
                        req_q.remaining <= req_q.remaining - 30'(chunk_q);
                        idx_q           <= '0;
                    end
                end
                DRAIN: begin
                    if (hs && !last_word) idx_q <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH) || zero_done_q;
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && last_word && (req_q.remaining == '0);
    assign out_data  = (state == DRAIN) ? rd_buf[idx_q] : '0;

endmodule

// File: tb/tb_sdr_stream_reader.sv
// Randomized bench for sdr_stream_reader: engine model, queue-based expected stream and chunk list, per-cycle compare.
module tb_sdr_stream_reader;
    localparam int MAX_NREAD = 64;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic [31:0]             base_addr = '0;
    logic [29:0]             total_words = '0;
    logic                    busy, done, sdr_readstart, out_valid, out_last;
    logic [31:0]             sdr_baseaddr, out_data;
    logic [29:0]             sdr_nelems;
    logic                    sdr_readend = 1'b0;
    logic [32*MAX_NREAD-1:0] sdr_readdata = '0;
    logic                    out_ready = 1'b0;

    sdr_stream_reader #(.MAX_NREAD(MAX_NREAD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .total_words(total_words), .busy(busy), .done(done),
        .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_readstart(sdr_readstart),
        .sdr_readend(sdr_readend), .sdr_readdata(sdr_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Reference model state
    logic [31:0] exp_q[$];
    logic [61:0] exp_chunks[$];
    int          done_due = -1;
    int          rs_due = -1;
    int          rd_end_cyc = -100;
    logic [31:0] seen_q[$];
    int          seen_cyc[$];
    logic [61:0] rs_log[$];
    int          last_cnt = 0;
    int          ready_mode = 0;
    int          eng_lat_min = 1, eng_lat_max = 4;
    logic [3:0]  pat = 4'b1001;

    // Engine: latch the request, answer after a random latency with garbage beyond nelems.
    logic [31:0] eng_addr;
    int          eng_n, eng_lat;
    always begin
        @(negedge clk);
        if (reset_n && sdr_readstart) begin
            eng_addr = sdr_baseaddr;
            eng_n    = int'(sdr_nelems);
            eng_lat  = $urandom_range(eng_lat_max, eng_lat_min);
            repeat (eng_lat) @(posedge clk);
            #1;
            for (int k = 0; k < MAX_NREAD; k++)
                sdr_readdata[32*k +: 32] = (k < eng_n) ? data_of(eng_addr + 32'(4*k)) : $urandom;
            sdr_readend = 1'b1;
            rd_end_cyc  = cyc;
            @(posedge clk);
            #1;
            sdr_readend = 1'b0;
            for (int k = 0; k < MAX_NREAD; k++) sdr_readdata[32*k +: 32] = $urandom;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(1, 0));
            default: out_ready = pat[cyc % 4];
        endcase
    end

    logic prev_valid = 1'b0, prev_ready = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            chk("done", done, cyc == done_due);
            if (sdr_readstart) begin
                if (exp_chunks.size() == 0) chk("readstart_unexpected", 1, 0);
                else chk("chunk_addr_nelems", {sdr_baseaddr, sdr_nelems}, exp_chunks.pop_front());
                rs_log.push_back({sdr_baseaddr, sdr_nelems});
                if (rs_due >= 0) begin
                    chk("start_to_readstart", cyc, rs_due);
                    rs_due = -1;
                end
            end
            if (prev_valid && !prev_ready) chk("hold_valid", out_valid, 1);
            if (out_valid && !prev_valid) chk("readend_to_valid", cyc, rd_end_cyc + 1);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("word_unexpected", 1, 0);
                else begin
                    chk("out_data", out_data, exp_q[0]);
                    chk("out_last", out_last, exp_q.size() == 1);
                    if (out_ready) begin
                        seen_q.push_back(out_data);
                        seen_cyc.push_back(cyc);
                        if (out_last) last_cnt++;
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_due = cyc + 1;
                    end
                end
            end else if (out_last) chk("out_last_without_valid", out_last, 0);
            prev_valid = out_valid;
            prev_ready = out_ready;
        end
    end

    task automatic run_req(input logic [31:0] b, input int n, input bit poke);
        bit poked = 0;
        bit fin = 0;
        int lim = n * 30 + 300;
        seen_q.delete(); seen_cyc.delete(); rs_log.delete(); last_cnt = 0;
        done_due = -1;
        @(posedge clk); #1;
        base_addr = b; total_words = 30'(n); start = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(data_of(b + 32'(4*i)));
        for (int j = 0; j * MAX_NREAD < n; j++)
            exp_chunks.push_back({b + 32'(4*MAX_NREAD*j), 30'((n - j*MAX_NREAD < MAX_NREAD) ? n - j*MAX_NREAD : MAX_NREAD)});
        if (n == 0) done_due = cyc + 1;
        else rs_due = cyc + 2;
        for (int t = 0; t < lim; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke && !poked && out_valid) begin
                start = 1'b1; total_words = 30'd5; base_addr = 32'h0000_8000; poked = 1;
            end
            if (done_due >= 0 && cyc > done_due) begin fin = 1; break; end
        end
        start = 1'b0;
        chk("request_completed", fin, 1);
        chk("words_left", exp_q.size(), 0);
        chk("chunks_left", exp_chunks.size(), 0);
        chk("busy_after_done", busy, 0);
        exp_q.delete(); exp_chunks.delete(); rs_due = -1;
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_readstart", sdr_readstart, 0);
        chk("rst_valid", out_valid, 0); chk("rst_last", out_last, 0);
        chk("rst_baseaddr", sdr_baseaddr, 0); chk("rst_nelems", sdr_nelems, 0); chk("rst_data", out_data, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        ready_mode = 0;
        run_req(32'h0000_1000, 3, 0);
        chk("t1_readstarts", rs_log.size(), 1);
        chk("t1_chunk", rs_log[0], {32'h0000_1000, 30'd3});
        chk("t1_w0", seen_q[0], 32'hDEAD_1000);
        chk("t1_w1", seen_q[1], 32'hDEAD_1004);
        chk("t1_w2", seen_q[2], 32'hDEAD_1008);
        chk("t1_consecutive", seen_cyc[2] - seen_cyc[0], 2);
        chk("t1_last_count", last_cnt, 1);

        run_req(32'h0002_0000, 130, 0);
        chk("t130_readstarts", rs_log.size(), 3);
        chk("t130_chunk0", rs_log[0], {32'h0002_0000, 30'd64});
        chk("t130_chunk1", rs_log[1], {32'h0002_0100, 30'd64});
        chk("t130_chunk2", rs_log[2], {32'h0002_0200, 30'd2});
        chk("t130_words", seen_q.size(), 130);
        chk("t130_final_word", seen_q[129], 32'hDEAF_0204);
        chk("t130_last_count", last_cnt, 1);

        run_req(32'h0003_0000, 128, 0);
        chk("t128_readstarts", rs_log.size(), 2);
        chk("t128_words", seen_q.size(), 128);

        run_req(32'h0004_0000, 0, 0);
        chk("t0_readstarts", rs_log.size(), 0);

        ready_mode = 2;
        run_req(32'h0005_0000, 20, 1);
        chk("bp_words", seen_q.size(), 20);
        chk("bp_last_count", last_cnt, 1);

        ready_mode = 0;
        run_req(32'hFFFF_FF00, 100, 0);
        chk("wrap_chunk1", rs_log[1], {32'h0000_0000, 30'd36});

        ready_mode = 1; eng_lat_max = 6;
        for (int r = 0; r < 8; r++)
            run_req($urandom & 32'hFFFF_FFFC, $urandom_range(150, 1), r[0]);

        // Reset while the engine read is outstanding.
        ready_mode = 0; eng_lat_min = 30; eng_lat_max = 30;
        seen_q.delete(); rs_log.delete(); done_due = -1;
        @(posedge clk); #1;
        base_addr = 32'h0006_0000; total_words = 30'd10; start = 1'b1;
        exp_chunks.push_back({32'h0006_0000, 30'd10});
        rs_due = cyc + 2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 20 && rs_log.size() == 0; t++) begin @(posedge clk); #1; end
        chk("rst_test_readstart_seen", rs_log.size(), 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_readstart", sdr_readstart, 0);
        chk("arst_valid", out_valid, 0); chk("arst_last", out_last, 0);
        chk("arst_baseaddr", sdr_baseaddr, 0); chk("arst_nelems", sdr_nelems, 0); chk("arst_data", out_data, 0);
        exp_q.delete(); exp_chunks.delete(); rs_due = -1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        chk("arst_no_words", seen_q.size(), 0);
        chk("arst_idle", busy, 0);
        eng_lat_min = 1; eng_lat_max = 4;

        run_req(32'h0007_0000, 5, 0);
        chk("post_rst_words", seen_q.size(), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sdr_stream_reader.md
Name: sdr_stream_reader

Overview:
- Sequencer that sits directly upstream of the Avalon SDRAM read/write engine and drives its read side.
- Splits an arbitrarily long read of 32-bit words into chunks of at most MAX_NREAD words.
- Issues one engine read per chunk, captures the returned flat buffer, and streams the words out one at a time over a valid/ready interface.
- Feeds scene data (triangles, BVH nodes) from SDRAM to the ray-tracing pipeline.

Parameters:
- MAX_NREAD, 64, max 32-bit words per engine read; must equal the engine's MAX_NREAD.
- TIMEOUT_CYCLES, 65535, watchdog limit in cycles; used only when SDR_STREAM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- base_addr  in  32  byte address of word 0; must be 4-byte aligned.
- total_words  in  30  number of 32-bit words to stream.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the request completes.
- sdr_baseaddr  out  32  chunk byte address to the engine.
- sdr_nelems  out  30  chunk word count to the engine, range 1..MAX_NREAD.
- sdr_readstart  out  1  one-cycle read request to the engine.
- sdr_readend  in  1  engine read-complete pulse.
- sdr_readdata  in  32*MAX_NREAD  engine flat read buffer; word k at bits [32k+31:32k].
- out_data  out  32  streamed word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  high with the final word of the whole request.
- err_timeout  out  1  exists only when SDR_STREAM_TIMEOUT_EN is defined; see Optional Feature.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: busy, done, sdr_readstart, out_valid, out_last, sdr_baseaddr, sdr_nelems, out_data.
  - Internal counters and the buffer are cleared.
- Reset mid-operation: the transfer is abandoned immediately. No done pulse is produced. The engine is left to finish its own transaction.
- States: IDLE, ISSUE, WAIT_RD, DRAIN, FINISH.
- IDLE:
  - start=1 with total_words>0: latch addr=base_addr and remaining=total_words, go to ISSUE.
  - start=1 with total_words=0: done pulses on the next cycle, stay in IDLE, no engine access.
  - start is ignored outside IDLE.
- ISSUE (one cycle):
  - chunk = min(remaining, MAX_NREAD).
  - Register sdr_baseaddr=addr, sdr_nelems=chunk, sdr_readstart=1, go to WAIT_RD.
  - sdr_readstart is high for exactly one cycle. sdr_baseaddr and sdr_nelems hold until the next ISSUE.
- WAIT_RD:
  - On sdr_readend=1, copy sdr_readdata into the local buffer in that same cycle.
  - Update addr += 4*chunk (32-bit wrap), remaining -= chunk, idx=0.
  - Go to DRAIN.
- DRAIN:
  - out_valid=1; out_data=buf[32*idx +: 32], driven from registered idx.
  - On out_valid&out_ready, idx increments.
  - Handshake with idx==chunk-1: go to ISSUE if remaining>0, else go to FINISH.
  - out_last=1 while idx==chunk-1 and remaining==0.
  - out_data, out_valid and out_last stay stable while out_ready=0.
- FINISH: done=1 for one cycle, go to IDLE.
- Output order is word 0 of the request first, ascending addresses throughout.
- Latency and throughput:
  - start to first engine request: 2 cycles (IDLE→ISSUE, ISSUE registers sdr_readstart).
  - readend to first out_valid: 1 cycle.
  - One word per cycle under continuous out_ready.
  - Chunk-to-chunk gap: ISSUE cycle plus engine latency.
- A word count that is an exact multiple of MAX_NREAD ends with no empty trailing chunk.
- total_words up to 2^30-1 must be handled: remaining is 30 bits, chunk is log2(MAX_NREAD)+1 bits.

Optional Feature:
- Macro SDR_STREAM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_RD.
  - If TIMEOUT_CYCLES elapse without sdr_readend, go to FINISH: done pulses and err_timeout goes high.
  - err_timeout stays high until the next accepted start or reset.
  - No words are emitted for the timed-out chunk.
- Not defined: no counter and no err_timeout port; WAIT_RD waits indefinitely.

Test Plan:
- base_addr=0x1000, total_words=3, out_ready=1, engine model returns words A,B,C:
  - One readstart with sdr_baseaddr=0x1000 and sdr_nelems=3.
  - Outputs A,B,C on consecutive cycles, out_last with C.
  - done pulses once, 1 cycle after the C handshake.
- total_words=130, MAX_NREAD=64:
  - Three readstarts with (addr, nelems) = (base,64), (base+256,64), (base+512,2).
  - 130 words in order; out_last only on word 130.
- total_words=128: exactly two chunks of 64; no third readstart; done follows word 128.
- total_words=0: done pulses 1 cycle after start; sdr_readstart never asserts.
- Backpressure: out_ready toggling 1,0,0,1 during DRAIN → out_data is stable while out_ready=0; no word is lost or duplicated. Assert start mid-transfer → it is ignored.
- Assert reset_n low in WAIT_RD → all outputs are 0 asynchronously and there is no done. With SDR_STREAM_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold readend → done and err_timeout at cycle 16 of WAIT_RD.
